// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// fighter_pkg : shared state encodings, hit codes and sizing helpers
// Revision    : 1.0
// ============================================================================
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_MOVE_FWD  = 4'd1,
    ST_MOVE_BACK = 4'd2,
    ST_B_START   = 4'd3,
    ST_B_ACTIVE  = 4'd4,
    ST_B_PULL    = 4'd5,
    ST_D_START   = 4'd6,
    ST_D_ACTIVE  = 4'd7,
    ST_D_PULL    = 4'd8,
    ST_HITSTUN   = 4'd9,
    ST_BLOCKSTUN = 4'd10
  } state_e;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BASIC = 2'b01;
  localparam logic [1:0] HIT_DIR   = 2'b10;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timer holds duration-1, so clog2(max duration) bits always suffice.
  function automatic int timer_width(input int max_dur);
    return (max_dur > 1) ? $clog2(max_dur) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_ctrl_if.sv
`default_nettype none
// ============================================================================
// fighter_ctrl_if : controls in / fighter status out for one fighter
// Revision        : 1.0
// ============================================================================
interface fighter_ctrl_if #(
  parameter int POS_W = 10
);
  logic             tick;
  logic             left;
  logic             right;
  logic             attack;
  logic [1:0]       hit_flag;
  logic             block_avail;
  logic [POS_W-1:0] posx;
  logic [3:0]       state;
  logic [1:0]       atk_active;
  logic             hit_taken;
  logic             block_used;

  modport master (
    output tick, left, right, attack, hit_flag, block_avail,
    input  posx, state, atk_active, hit_taken, block_used
  );

  modport slave (
    input  tick, left, right, attack, hit_flag, block_avail,
    output posx, state, atk_active, hit_taken, block_used
  );
endinterface
`default_nettype wire

// File: rtl/fighter_timer.sv
`default_nettype none
// ============================================================================
// fighter_timer : loadable down-counter with zero flag for phase durations
// Revision      : 1.0
// ============================================================================
module fighter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign zero = (cnt_r == '0);
endmodule
`default_nettype wire

// File: rtl/fighter_ctrl.sv
`default_nettype none
// ============================================================================
// fighter_ctrl : movement, attack phasing and hit/block response of a fighter
// Revision     : 1.0
// ============================================================================
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int SIDE       = 0,
  parameter int POS_W      = 10,
  parameter int X_MIN      = 10,
  parameter int X_MAX      = 517,
  parameter int X_START    = (SIDE != 0) ? 427 : 100,
  parameter int SPD_FWD    = 3,
  parameter int SPD_BACK   = 2,
  parameter int B_STARTUP  = 5,
  parameter int B_ACTIVE   = 2,
  parameter int B_RECOVERY = 16,
  parameter int D_STARTUP  = 4,
  parameter int D_ACTIVE   = 3,
  parameter int D_RECOVERY = 15,
  parameter int HS_B       = 15,
  parameter int HS_D       = 14,
  parameter int BS_B       = 13,
  parameter int BS_D       = 12
) (
  input  logic          clk,
  input  logic          rst,
  fighter_ctrl_if.slave bus
);
  localparam int MAX_DUR = max_of(
      max_of(max_of(B_STARTUP, B_ACTIVE), max_of(B_RECOVERY, D_STARTUP)),
      max_of(max_of(D_ACTIVE, D_RECOVERY),
             max_of(max_of(HS_B, HS_D), max_of(BS_B, BS_D))));
  localparam int TW  = timer_width(MAX_DUR);
  localparam int PW1 = POS_W + 1;

  localparam logic [POS_W:0] LIM_LO   = PW1'(X_MIN);
  localparam logic [POS_W:0] LIM_HI   = PW1'(X_MAX);
  localparam logic [POS_W:0] AMT_FWD  = PW1'(SPD_FWD);
  localparam logic [POS_W:0] AMT_BACK = PW1'(SPD_BACK);
  localparam logic           FWD_UP   = (SIDE == 0) ? 1'b1 : 1'b0;

  state_e           state_r, state_n, move_state;
  logic [POS_W-1:0] posx_r, posx_n, posx_step;
  logic [1:0]       pend_r;
  logic             atk_prev_r, hit_taken_r, block_used_r;
  logic             hit_taken_n, block_used_n;
  logic             new_press, hit_pend, hit_in, toward, away;
  logic             timer_load, timer_dec, timer_zero;
  logic [TW-1:0]    timer_val;
  logic             step_up;
  logic [POS_W:0]   step_amt, px_ext, px_sum, px_dif;

  assign new_press = bus.attack & ~atk_prev_r;
  assign hit_pend  = (pend_r == HIT_BASIC) || (pend_r == HIT_DIR);
  assign hit_in    = (bus.hit_flag == HIT_BASIC) || (bus.hit_flag == HIT_DIR);
  assign toward    = (SIDE != 0) ? bus.left  : bus.right;
  assign away      = (SIDE != 0) ? bus.right : bus.left;

  always_comb begin
    move_state = ST_IDLE;
    if (bus.left && bus.right) move_state = ST_MOVE_BACK;
    else if (toward)           move_state = ST_MOVE_FWD;
    else if (away)             move_state = ST_MOVE_BACK;
  end

  // Saturating position step; one spare bit keeps the overflow test honest.
  assign step_up  = (state_r == ST_MOVE_FWD) ? FWD_UP : ~FWD_UP;
  assign step_amt = (state_r == ST_MOVE_FWD) ? AMT_FWD : AMT_BACK;
  assign px_ext   = {1'b0, posx_r};
  assign px_sum   = px_ext + step_amt;
  assign px_dif   = px_ext - step_amt;

  always_comb begin
    posx_step = posx_r;
    if (step_up) begin
      posx_step = (px_sum > LIM_HI) ? LIM_HI[POS_W-1:0] : px_sum[POS_W-1:0];
    end else begin
      posx_step = (px_ext < (LIM_LO + step_amt)) ? LIM_LO[POS_W-1:0] : px_dif[POS_W-1:0];
    end
  end

  always_comb begin
    state_n      = state_r;
    posx_n       = posx_r;
    hit_taken_n  = 1'b0;
    block_used_n = 1'b0;
    if (bus.tick) begin
      if (hit_pend && (state_r <= ST_D_PULL)) begin
        if ((state_r == ST_MOVE_BACK) && bus.block_avail) begin
          state_n      = ST_BLOCKSTUN;
          block_used_n = 1'b1;
        end else begin
          state_n     = ST_HITSTUN;
          hit_taken_n = 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: state_n = new_press ? ST_B_START : move_state;
          ST_MOVE_FWD, ST_MOVE_BACK: begin
            if (new_press) begin
              state_n = ST_D_START;
            end else begin
              state_n = move_state;
              if (move_state == state_r) posx_n = posx_step;
            end
          end
          ST_B_START:  if (timer_zero) state_n = ST_B_ACTIVE;
          ST_B_ACTIVE: if (timer_zero) state_n = ST_B_PULL;
          ST_D_START:  if (timer_zero) state_n = ST_D_ACTIVE;
          ST_D_ACTIVE: if (timer_zero) state_n = ST_D_PULL;
          ST_B_PULL, ST_D_PULL, ST_HITSTUN, ST_BLOCKSTUN: begin
            if (timer_zero) state_n = new_press ? ST_B_START : move_state;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  // No timed state can re-enter itself, so any change of state means a fresh load.
  assign timer_load = bus.tick && (state_n != state_r);
  assign timer_dec  = bus.tick && (state_n == state_r);

  always_comb begin
    timer_val = '0;
    case (state_n)
      ST_B_START:   timer_val = TW'(B_STARTUP - 1);
      ST_B_ACTIVE:  timer_val = TW'(B_ACTIVE - 1);
      ST_B_PULL:    timer_val = TW'(B_RECOVERY - 1);
      ST_D_START:   timer_val = TW'(D_STARTUP - 1);
      ST_D_ACTIVE:  timer_val = TW'(D_ACTIVE - 1);
      ST_D_PULL:    timer_val = TW'(D_RECOVERY - 1);
      ST_HITSTUN:   timer_val = (pend_r == HIT_BASIC) ? TW'(HS_B - 1) : TW'(HS_D - 1);
      ST_BLOCKSTUN: timer_val = (pend_r == HIT_BASIC) ? TW'(BS_B - 1) : TW'(BS_D - 1);
      default:      timer_val = '0;
    endcase
  end

  fighter_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      posx_r       <= POS_W'(X_START);
      pend_r       <= HIT_NONE;
      atk_prev_r   <= 1'b0;
      hit_taken_r  <= 1'b0;
      block_used_r <= 1'b0;
    end else begin
      hit_taken_r  <= hit_taken_n;
      block_used_r <= block_used_n;
      if (bus.tick) begin
        state_r    <= state_n;
        posx_r     <= posx_n;
        atk_prev_r <= bus.attack;
        // A hit arriving on a tick cycle waits for the following tick.
        pend_r     <= hit_in ? bus.hit_flag : HIT_NONE;
      end else if (hit_in) begin
        pend_r <= bus.hit_flag;
      end
    end
  end

  assign bus.posx       = posx_r;
  assign bus.state      = state_r;
  assign bus.atk_active = {state_r == ST_D_ACTIVE, state_r == ST_B_ACTIVE};
  assign bus.hit_taken  = hit_taken_r;
  assign bus.block_used = block_used_r;
endmodule
`default_nettype wire
